merge_out_packer: RTL and testbench

// Sink directly downstream of the 16-wide merger tree root. Accepts one P-record sorted word
// per i_write, buffers it in a small FIFO and down-converts it to OUT_P-record beats on a

---
 rtl/merge_out_packer_pkg.sv | 18 +
 rtl/packer_fifo.sv | 69 ++++++
 rtl/merge_out_packer.sv | 175 +++++++++++++++++
 tb/tb_merge_out_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_out_packer_pkg.sv
// Shared constants for the merger-tree back end: FSM state encodings and default datapath sizes
// used by the tree, this packer and the memory writer.
package merge_pkg;

    localparam int MERGE_DATA_WIDTH = 32;
    localparam int MERGE_P          = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } packer_state_e;

endpackage

// File: rtl/packer_fifo.sv
// Synchronous word FIFO with flush. A committed write becomes visible to the read side one
// cycle later, so the head word is always read from settled storage.
module packer_fifo
    import merge_pkg::*;
#(
    parameter int WIDTH = MERGE_P * MERGE_DATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_wr_ptr_d;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr_d == r_rd_ptr);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Word storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointers; the delayed write pointer gates read-side visibility
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_wr_ptr_d <= '0;
            r_rd_ptr   <= '0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_wr_ptr_d <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            r_wr_ptr_d <= r_wr_ptr;
        end
    end

endmodule

// File: rtl/merge_out_packer.sv
// Buffers P-record words from the merger tree root and re-emits them as OUT_P-record beats on a
// valid/ready stream, counting records against a programmed run length.
module merge_out_packer
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = MERGE_DATA_WIDTH,
    parameter int P          = MERGE_P,
    parameter int OUT_P      = 4,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [CNT_WIDTH-1:0]        i_total_records,
    input  logic [P*DATA_WIDTH-1:0]     i_data,
    input  logic                        i_write,
    output logic                        o_ready,
    output logic [OUT_P*DATA_WIDTH-1:0] o_m_data,
    output logic                        o_m_valid,
    input  logic                        i_m_ready,
    output logic                        o_m_last,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int WORD_W  = P * DATA_WIDTH;
    localparam int BEAT_W  = OUT_P * DATA_WIDTH;
    localparam int SLICES  = P / OUT_P;
    localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int CW      = $clog2(DEPTH) + 1;

    packer_state_e         r_state;
    packer_state_e         w_state_nxt;
    logic [SLICE_W-1:0]    r_slice;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [BEAT_W-1:0]     r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [WORD_W-1:0]     w_head;
    logic                  w_empty;
    logic                  w_full;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_nxt;
    logic [BEAT_W-1:0]     w_slice;
    logic                  w_start;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_last_beat;
    logic                  w_done_hs;
    logic                  w_flush;

    assign w_start     = i_start && (r_state != ST_RUN);
    assign w_push      = i_write && r_ready;
    assign w_last_beat = (r_remaining == CNT_WIDTH'(OUT_P));
    assign w_load      = (r_state == ST_RUN) && !w_empty && (r_remaining != '0)
                         && (!r_m_valid || i_m_ready);
    // The last beat of a run also retires its word so residual slices never surface.
    assign w_pop       = w_load && ((r_slice == SLICE_W'(SLICES - 1)) || w_last_beat);
    assign w_done_hs   = (r_state == ST_RUN) && r_m_valid && r_m_last && i_m_ready;
    assign w_flush     = w_start || w_done_hs;
    assign w_slice     = w_head[r_slice * BEAT_W +: BEAT_W];

    packer_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (i_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Occupancy after this edge, used to register o_ready one cycle ahead
    always_comb begin
        w_count_nxt = w_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop && !w_full) begin
            w_count_nxt = w_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = w_count - CW'(1);
        end else begin
            w_count_nxt = w_count;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt = (i_total_records == '0) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (w_done_hs) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status flags, record counter, slice counter and output beat register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= '0;
            r_slice     <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_data    <= '0;
        end else begin
            r_ready <= (w_state_nxt == ST_RUN) && (w_count_nxt != CW'(DEPTH));
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
            r_err   <= r_err | (i_write & ~r_ready);
            if (w_start) begin
                r_remaining <= i_total_records;
                r_slice     <= '0;
            end else if (w_load) begin
                r_remaining <= r_remaining - CNT_WIDTH'(OUT_P);
                r_slice     <= w_pop ? '0 : r_slice + SLICE_W'(1);
            end
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_slice;
                r_m_last  <= w_last_beat;
            end else if (i_m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign o_ready   = r_ready;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_m_data  = r_m_data;
    assign o_m_valid = r_m_valid;
    assign o_m_last  = r_m_last;

endmodule

// File: tb/tb_merge_out_packer.sv
// Self-checking bench for merge_out_packer: hand-written timing sequences, a table of runs and a
// beat scoreboard fed from the words the bench writes.
module tb_merge_out_packer;

    localparam int DW = 32, P = 16, OUT_P = 4, DEPTH = 4, CW = 32;
    localparam int WW = P * DW, BW = OUT_P * DW, SL = P / OUT_P;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_start = 1'b0;
    logic [CW-1:0] total = '0;
    logic [WW-1:0] i_data = '0;
    logic          i_write = 1'b0;
    logic          i_m_ready = 1'b0;
    logic          o_ready, o_m_valid, o_m_last, o_busy, o_done, o_err;
    logic [BW-1:0] o_m_data;

    typedef struct { logic [BW-1:0] data; logic last; } beat_t;
    typedef struct { int total; int words; int exp_beats; } vec_t;

    beat_t q[$];
    vec_t  vecs[5];
    int errors = 0, checks = 0, beat_cnt = 0, beats_left = 0, rdy_mode = 1, run_id = 0;

    merge_out_packer #(
        .DATA_WIDTH(DW), .P(P), .OUT_P(OUT_P), .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_total_records(total),
        .i_data(i_data), .i_write(i_write), .o_ready(o_ready), .o_m_data(o_m_data),
        .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_last(o_m_last),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] mk_word(input int base);
        logic [WW-1:0] d;
        for (int r = 0; r < P; r++) d[r*DW +: DW] = DW'(base + r);
        return d;
    endfunction

    task automatic score_word(input logic [WW-1:0] d);
        beat_t e;
        for (int s = 0; s < SL; s++) begin
            if (beats_left > 0) begin
                e.data = d[s*BW +: BW];
                e.last = (beats_left == 1);
                q.push_back(e);
                beats_left--;
            end
        end
    endtask

    task automatic start_run(input int t);
        total = CW'(t);
        i_start = 1'b1;
        beats_left = t / OUT_P;
        beat_cnt = 0;
        run_id++;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic write_word(input logic [WW-1:0] d);
        int n = 0;
        while (!o_ready && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (!o_ready) begin
            errors++;
            $display("FAIL write_timeout: o_ready still %b after %0d cycles", o_ready, n);
        end else begin
            i_data = d;
            i_write = 1'b1;
            score_word(d);
            cyc();
            i_write = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int exp_beats);
        int n = 0;
        while (!o_done && n < 1000) begin
            cyc();
            n++;
        end
        chk({name, "_done"}, o_done, 1);
        chk({name, "_beats"}, beat_cnt, exp_beats);
        chk({name, "_sb_empty"}, q.size(), 0);
        chk({name, "_busy"}, o_busy, 0);
        chk({name, "_ready"}, o_ready, 0);
        chk({name, "_valid"}, o_m_valid, 0);
    endtask

    // Downstream ready: 0 = stalled, 1 = always ready, otherwise random
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       i_m_ready = 1'b0;
            1:       i_m_ready = 1'b1;
            default: i_m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: every accepted beat against the queue head; stalled beats must hold the head
    always @(posedge clk) begin
        if (rst_n && o_m_valid) begin
            if (i_m_ready) begin
                checks++;
                beat_cnt++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h last=%b, none expected", o_m_data, o_m_last);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    if (o_m_data !== e.data || o_m_last !== e.last) begin
                        errors++;
                        $display("FAIL beat: got data=%h last=%b expected data=%h last=%b",
                                 o_m_data, o_m_last, e.data, e.last);
                    end
                end
            end else if (q.size() > 0) begin
                checks++;
                if (o_m_data !== q[0].data) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h", o_m_data, q[0].data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] b0;
        vecs[0] = '{4, 1, 1};
        vecs[1] = '{8, 2, 2};
        vecs[2] = '{16, 2, 4};
        vecs[3] = '{32, 2, 8};
        vecs[4] = '{48, 3, 12};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", o_ready, 0); chk("rst_valid", o_m_valid, 0); chk("rst_last", o_m_last, 0);
        chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0); chk("rst_err", o_err, 0);
        chk("rst_data", o_m_data, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("idle_ready", o_ready, 0);

        // Latency and ordering of a single 16-record word
        rdy_mode = 1;
        start_run(16);
        chk("t2_busy", o_busy, 1); chk("t2_ready", o_ready, 1); chk("t2_done0", o_done, 0);
        i_data = mk_word(0);
        i_write = 1'b1;
        score_word(i_data);
        cyc();
        i_write = 1'b0;
        chk("t2_valid_t", o_m_valid, 0);
        cyc(); chk("t2_valid_t1", o_m_valid, 0);
        cyc(); chk("t2_valid_t2", o_m_valid, 1);
        b0 = 128'h00000003_00000002_00000001_00000000;
        chk("t2_beat0", o_m_data, b0);
        chk("t2_last_b0", o_m_last, 0);
        cyc(); cyc(); chk("t2_last_b2", o_m_last, 0);
        cyc(); chk("t2_last_b3", o_m_last, 1); chk("t2_valid_b3", o_m_valid, 1);
        cyc(); chk("t2_done1", o_done, 1);
        wait_done("t2", 4);

        // Total shorter than a word: residual slices dropped
        start_run(8);
        write_word(mk_word((run_id << 16)));
        wait_done("t4", 2);

        // Empty run
        start_run(0);
        chk("t5_done", o_done, 1); chk("t5_busy", o_busy, 0); chk("t5_ready", o_ready, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t5_valid", o_m_valid, 0);
            chk("t5_ready_hold", o_ready, 0);
        end

        // Table of runs, downstream always ready
        for (int v = 0; v < 5; v++) begin
            start_run(vecs[v].total);
            chk("tbl_busy", o_busy, 1);
            chk("tbl_done_clr", o_done, 0);
            for (int w = 0; w < vecs[v].words; w++) write_word(mk_word((run_id << 16) + (w << 8)));
            wait_done("tbl", vecs[v].exp_beats);
        end

        // Back-pressure: FIFO fills, overflow write flags o_err, then drain
        rdy_mode = 0;
        cyc(); cyc();
        start_run(32);
        for (int w = 0; w < DEPTH; w++) write_word(mk_word((run_id << 16) + (w << 8)));
        chk("t3_ready_full", o_ready, 0);
        chk("t3_err0", o_err, 0);
        i_data = mk_word(32'h00ff0000);
        i_write = 1'b1;
        cyc();
        i_write = 1'b0;
        chk("t3_err1", o_err, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_stall_valid", o_m_valid, 1);
        end
        rdy_mode = 1;
        wait_done("t3", 8);
        chk("t3_err_sticky", o_err, 1);

        // Random downstream ready
        rdy_mode = 2;
        start_run(64);
        for (int w = 0; w < 4; w++) write_word(mk_word((run_id << 16) + (w << 8)));
        wait_done("t6", 16);

        // Reset in the middle of a run with two words buffered
        rdy_mode = 0;
        cyc(); cyc();
        start_run(64);
        write_word(mk_word((run_id << 16)));
        write_word(mk_word((run_id << 16) + 256));
        cyc(); cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        beats_left = 0;
        chk("t1_ready", o_ready, 0); chk("t1_valid", o_m_valid, 0); chk("t1_last", o_m_last, 0);
        chk("t1_busy", o_busy, 0); chk("t1_done", o_done, 0); chk("t1_err", o_err, 0);
        chk("t1_data", o_m_data, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_post_ready", o_ready, 0);
            chk("t1_post_busy", o_busy, 0);
            chk("t1_post_valid", o_m_valid, 0);
        end
        start_run(16);
        write_word(mk_word((run_id << 16)));
        wait_done("t1_recover", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
